// File: rtl/clk_div_glitch_free_multi.sv
// Bank of independent integer clock dividers with runtime ratio updates.
// A new ratio or a stop request is applied only at a period boundary, so every pulse is full length.
module clk_div_glitch_free_multi #(
  parameter int NUM_CHANNELS = 4,
  parameter int DIV_WIDTH    = 8,
  parameter int DEFAULT_DIV  = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_CHANNELS-1:0]           en_i,
  input  logic [NUM_CHANNELS*DIV_WIDTH-1:0] div_i,
  input  logic [NUM_CHANNELS-1:0]           div_valid_i,
  output logic [NUM_CHANNELS-1:0]           div_ready_o,
  output logic [NUM_CHANNELS-1:0]           clk_o,
  output logic [NUM_CHANNELS-1:0]           running_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] active_q, active_d;
    logic [DIV_WIDTH-1:0] pending_q, pending_d;
    logic                 pend_q, pend_d;
    logic                 clk_q;
    logic [DIV_WIDTH-1:0] div_req, half_len, low_len;
    logic                 xfer, apply;
    logic                 running_c, ready_c;

    assign div_req  = div_i[c*DIV_WIDTH +: DIV_WIDTH];
    assign half_len = active_q >> 1;
    assign low_len  = active_q - half_len;
    assign xfer     = div_valid_i[c] && !pend_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        active_q  <= DIV_RST;
        pending_q <= DIV_RST;
        pend_q    <= 1'b0;
        clk_q     <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        active_q  <= active_d;
        pending_q <= pending_d;
        pend_q    <= pend_d;
        clk_q     <= (state_d == ST_HIGH);
      end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      active_d  = active_q;
      pending_d = pending_q;
      pend_d    = pend_q;
      apply     = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          apply = pend_q;
          cnt_d = '0;
          if (en_i[c]) state_d = ST_HIGH;
        end
        ST_HIGH: begin
          if (cnt_q == half_len - ONE) begin
            cnt_d   = '0;
            state_d = ST_LOW;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        ST_LOW: begin
          if (cnt_q == low_len - ONE) begin
            apply   = pend_q;
            cnt_d   = '0;
            state_d = en_i[c] ? ST_HIGH : ST_IDLE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // apply needs pend_q=1 and xfer needs pend_q=0, so they never collide
      if (apply) begin
        active_d = pending_q;
        pend_d   = 1'b0;
      end
      if (xfer) begin
        pending_d = (div_req < DIV_MIN) ? DIV_MIN : div_req;
        pend_d    = 1'b1;
      end
    end

    always_comb begin
      running_c = (state_q != ST_IDLE);
      ready_c   = !pend_q;
    end

    assign clk_o[c]       = clk_q;
    assign running_o[c]   = running_c;
    assign div_ready_o[c] = ready_c;
  end

endmodule

// File: tb/tb_clk_div_glitch_free_multi.sv
// Scoreboard bench: a period-position model predicts clk_o/running_o/div_ready_o each cycle,
// the monitor compares them and tracks pulse widths of channel 0 for directed checks.
module tb_clk_div_glitch_free_multi;
  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int DEF = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NCH-1:0]    en_i;
  logic [NCH*DW-1:0] div_i;
  logic [NCH-1:0]    div_valid_i;
  logic [NCH-1:0]    div_ready_o;
  logic [NCH-1:0]    clk_o;
  logic [NCH-1:0]    running_o;

  clk_div_glitch_free_multi #(
    .NUM_CHANNELS(NCH),
    .DIV_WIDTH   (DW),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .div_i      (div_i),
    .div_valid_i(div_valid_i),
    .div_ready_o(div_ready_o),
    .clk_o      (clk_o),
    .running_o  (running_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [NCH-1:0] clk;
    logic [NCH-1:0] run;
    logic [NCH-1:0] rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference model: position within the period, pulse high while pos < D/2.
  int m_pos[NCH];
  int m_act[NCH];
  int m_pend[NCH];
  bit m_pv[NCH];
  bit m_run[NCH];

  always @(posedge clk_i) begin
    exp_t e;
    int   req;
    bit   xfer;
    for (int c = 0; c < NCH; c++) begin
      req = int'(div_i[c*DW +: DW]);
      if (rst_i) begin
        m_run[c] = 1'b0;
        m_pos[c] = 0;
        m_act[c] = DEF;
        m_pv[c]  = 1'b0;
      end else begin
        xfer = div_valid_i[c] && !m_pv[c];
        if (!m_run[c]) begin
          if (m_pv[c]) begin
            m_act[c] = m_pend[c];
            m_pv[c]  = 1'b0;
          end
          if (en_i[c]) begin
            m_run[c] = 1'b1;
            m_pos[c] = 0;
          end
        end else if (m_pos[c] == m_act[c] - 1) begin
          if (m_pv[c]) begin
            m_act[c] = m_pend[c];
            m_pv[c]  = 1'b0;
          end
          m_pos[c] = 0;
          m_run[c] = en_i[c];
        end else begin
          m_pos[c]++;
        end
        if (xfer) begin
          m_pend[c] = (req < 2) ? 2 : req;
          m_pv[c]   = 1'b1;
        end
      end
      e.clk[c] = m_run[c] && (m_pos[c] < m_act[c] / 2);
      e.run[c] = m_run[c];
      e.rdy[c] = !m_pv[c];
    end
    exp_q.push_back(e);
  end

  // Monitor: compare on the falling edge, measure channel-0 pulse widths.
  logic prev_clk0 = 1'b0;
  int   hi_cnt = 0, lo_cnt = 0, last_hi = 0, last_lo = 0;

  always @(negedge clk_i) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("clk_o", 32'(clk_o), 32'(e.clk));
      check("running_o", 32'(running_o), 32'(e.run));
      check("div_ready_o", 32'(div_ready_o), 32'(e.rdy));
    end
    if (clk_o[0] == prev_clk0) begin
      if (clk_o[0]) hi_cnt++;
      else lo_cnt++;
    end else if (clk_o[0]) begin
      last_lo = lo_cnt;
      hi_cnt  = 1;
    end else begin
      last_hi = hi_cnt;
      lo_cnt  = 1;
    end
    prev_clk0 = clk_o[0];
  end

  task automatic write_div(input int ch, input int val);
    div_i[ch*DW +: DW] = DW'(val);
    div_valid_i[ch]    = 1'b1;
    @(negedge clk_i);
    div_valid_i[ch]    = 1'b0;
  endtask

  // Returns at the falling edge in the first HIGH cycle of channel ch.
  task automatic wait_rise(input int ch);
    logic prev;
    bit   seen;
    prev = clk_o[ch];
    seen = 1'b0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      @(negedge clk_i);
      if (clk_o[ch] && !prev) seen = 1'b1;
      prev = clk_o[ch];
    end
    if (!seen) check("wait_rise_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_pulse(input string tag, input int hi, input int lo);
    check({tag, "_high"}, 32'(last_hi), 32'(hi));
    check({tag, "_low"}, 32'(last_lo), 32'(lo));
  endtask

  initial begin
    rst_i       = 1'b1;
    en_i        = '0;
    div_i       = '0;
    div_valid_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Default ratio after reset
    en_i[0] = 1'b1;
    repeat (12) @(negedge clk_i);
    check_pulse("default_d2", 1, 1);

    // Ratio 4, then 7 written mid-HIGH
    write_div(0, 4);
    repeat (20) @(negedge clk_i);
    check_pulse("d4", 2, 2);
    wait_rise(0);
    @(negedge clk_i);
    write_div(0, 7);
    repeat (30) @(negedge clk_i);
    check_pulse("d7", 3, 4);

    // Clamp of 0 and 1, then the largest ratio
    write_div(0, 0);
    repeat (24) @(negedge clk_i);
    check_pulse("clamp0", 1, 1);
    write_div(0, 7);
    repeat (24) @(negedge clk_i);
    write_div(0, 1);
    repeat (24) @(negedge clk_i);
    check_pulse("clamp1", 1, 1);
    write_div(0, 255);
    repeat (600) @(negedge clk_i);
    check_pulse("d255", 127, 128);

    // Stop in first HIGH cycle at D=6, then stop cancelled within LOW
    write_div(0, 6);
    repeat (300) @(negedge clk_i);
    check_pulse("d6", 3, 3);
    wait_rise(0);
    en_i[0] = 1'b0;
    repeat (12) @(negedge clk_i);
    check("stopped_running", 32'(running_o[0]), 32'd0);
    check_pulse("stop_last_period", 3, 3);
    en_i[0] = 1'b1;
    wait_rise(0);
    en_i[0] = 1'b0;
    repeat (4) @(negedge clk_i);
    en_i[0] = 1'b1;
    repeat (14) @(negedge clk_i);
    check_pulse("stop_cancelled", 3, 3);

    // Reset mid-HIGH with an update pending
    wait_rise(0);
    write_div(0, 9);
    rst_i   = 1'b1;
    en_i[0] = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_clk", 32'(clk_o[0]), 32'd0);
    check("rst_ready", 32'(div_ready_o[0]), 32'd1);
    en_i[0] = 1'b1;
    repeat (12) @(negedge clk_i);
    check_pulse("after_rst", 1, 1);

    // All channels, random updates and enables
    div_i       = {8'd9, 8'd5, 8'd3, 8'd2};
    div_valid_i = '1;
    @(negedge clk_i);
    div_valid_i = '0;
    en_i        = '1;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk_i);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 63) == 0) en_i[c] = ~en_i[c];
        div_valid_i[c] = ($urandom_range(0, 31) == 0);
        case ($urandom_range(0, 7))
          0: div_i[c*DW +: DW] = 8'd2;
          1: div_i[c*DW +: DW] = 8'd3;
          2: div_i[c*DW +: DW] = 8'd5;
          3: div_i[c*DW +: DW] = 8'd9;
          4: div_i[c*DW +: DW] = 8'd0;
          5: div_i[c*DW +: DW] = 8'd1;
          6: div_i[c*DW +: DW] = DW'($urandom_range(2, 20));
          default: div_i[c*DW +: DW] = 8'd4;
        endcase
      end
    end
    div_valid_i = '0;
    repeat (4) @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
